// File: rtl/apb_master_if.sv
// APB master bridge: turns a local request/ready handshake into a single
// APB transfer (SETUP then ACCESS) with a bounded wait-state timeout.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer in flight; local request may be accepted
// SETUP  | PSEL high, PENABLE low, lasts exactly one cycle
// ACCESS | PSEL and PENABLE high, waiting for PREADY or the timeout
module apb_master_if #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLE  = 16,
  localparam int STRB_WIDTH    = APB_DATA_WIDTH / 8
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rst_in,
  input  logic                      other_req_in,
  input  logic [APB_ADDR_WIDTH-1:0] other_addr_in,
  input  logic                      other_write_in,
  input  logic [APB_DATA_WIDTH-1:0] other_wdata_in,
  input  logic [STRB_WIDTH-1:0]     other_strb_in,
  input  logic [2:0]                other_prot_in,
  output logic                      other_ready_out,
  output logic                      other_done_out,
  output logic [APB_DATA_WIDTH-1:0] other_rdata_out,
  output logic                      other_error_out,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
  output logic                      apb_psel_out,
  output logic                      apb_penable_out,
  output logic                      apb_write_out,
  output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
  output logic [STRB_WIDTH-1:0]     apb_strb_out,
  output logic [2:0]                apb_prot_out,
  input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic                      apb_ready_in,
  input  logic                      apb_slverr_in
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Wide enough to hold TIMEOUT_CYCLE itself; it only ever counts up to
  // TIMEOUT_CYCLE-1, so it can never wrap.
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLE + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLE - 1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] wait_cnt;

  // Local side may hand over a request only while idle and out of reset.
  always_comb begin
    other_ready_out = (state == ST_IDLE) && !apb_rst_in;
  end

  // Transfer sequencer: all APB and completion outputs are registered here.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state           <= ST_IDLE;
      wait_cnt        <= '0;
      other_done_out  <= 1'b0;
      other_rdata_out <= '0;
      other_error_out <= 1'b0;
      apb_addr_out    <= '0;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
      apb_write_out   <= 1'b0;
      apb_wdata_out   <= '0;
      apb_strb_out    <= '0;
      apb_prot_out    <= '0;
    end else begin
      other_done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          apb_penable_out <= 1'b0;
          if (other_req_in) begin
            apb_addr_out  <= other_addr_in;
            apb_write_out <= other_write_in;
            apb_prot_out  <= other_prot_in;
            // Reads drive a quiet data bus and no byte strobes.
            apb_wdata_out <= other_write_in ? other_wdata_in : '0;
            apb_strb_out  <= other_write_in ? other_strb_in : '0;
            apb_psel_out  <= 1'b1;
            state         <= ST_SETUP;
          end else begin
            apb_psel_out <= 1'b0;
          end
        end
        ST_SETUP: begin
          apb_penable_out <= 1'b1;
          wait_cnt        <= '0;
          state           <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apb_ready_in) begin
            // Ready beats the timeout even on the last allowed cycle.
            other_done_out  <= 1'b1;
            other_error_out <= apb_slverr_in;
            other_rdata_out <= apb_write_out ? '0 : apb_rdata_in;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            state           <= ST_IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            other_done_out  <= 1'b1;
            other_error_out <= 1'b1;
            other_rdata_out <= '0;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            state           <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          apb_psel_out    <= 1'b0;
          apb_penable_out <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_if.md
APB_MASTER_IF -- requirements
Module: apb_master_if

Interface
REQ-001 Parameter APB_DATA_WIDTH, default 32, APB data bus width in bits (multiple of 8).
REQ-002 Parameter APB_ADDR_WIDTH, default 32, APB address bus width in bits.
REQ-003 Parameter TIMEOUT_CYCLE, default 16, maximum ACCESS-phase cycles before abort (minimum 1).
REQ-004 Derived STRB_WIDTH = APB_DATA_WIDTH/8.
REQ-005 Ports SHALL be:
  apb_clk_in  in  1  single clock, all logic on rising edge
  apb_rst_in  in  1  reset, synchronous, active-high
  other_req_in  in  1  local request valid
  other_addr_in  in  APB_ADDR_WIDTH  request address
  other_write_in  in  1  1=write, 0=read
  other_wdata_in  in  APB_DATA_WIDTH  write data
  other_strb_in  in  STRB_WIDTH  write byte strobes
  other_prot_in  in  3  protection attributes
  other_ready_out  out  1  request accepted when high with other_req_in
  other_done_out  out  1  one-cycle completion pulse
  other_rdata_out  out  APB_DATA_WIDTH  read data, valid with other_done_out
  other_error_out  out  1  error flag, valid with other_done_out
  apb_addr_out  out  APB_ADDR_WIDTH  PADDR
  apb_psel_out  out  1  PSEL
  apb_penable_out  out  1  PENABLE
  apb_write_out  out  1  PWRITE
  apb_wdata_out  out  APB_DATA_WIDTH  PWDATA
  apb_strb_out  out  STRB_WIDTH  PSTRB
  apb_prot_out  out  3  PPROT
  apb_rdata_in  in  APB_DATA_WIDTH  PRDATA
  apb_ready_in  in  1  PREADY
  apb_slverr_in  in  1  PSLVERR

Function
REQ-006 FSM states IDLE, SETUP, ACCESS; all APB and other_*_out outputs except other_ready_out SHALL be registered.
REQ-007 other_ready_out SHALL be 1 exactly when state is IDLE and not in reset (decoded from state register only).
REQ-008 IDLE with other_req_in=1: capture addr/write/wdata/strb/prot onto apb_*_out, set psel=1, penable=0, go SETUP; other_req_in=0: stay IDLE, psel=0, penable=0.
REQ-009 On reads, apb_strb_out SHALL be captured as all zeros and apb_wdata_out as 0 regardless of inputs.
REQ-010 SETUP lasts exactly one cycle: next edge sets penable=1, clears timeout counter, goes ACCESS.
REQ-011 apb_addr_out, apb_write_out, apb_wdata_out, apb_strb_out, apb_prot_out SHALL not change from SETUP entry until return to IDLE.
REQ-012 ACCESS with apb_ready_in=1: at that edge other_done_out=1, other_error_out=apb_slverr_in, other_rdata_out=apb_rdata_in for reads or 0 for writes; psel=0, penable=0; go IDLE.
REQ-013 ACCESS with apb_ready_in=0 and counter < TIMEOUT_CYCLE-1: increment counter, stay ACCESS.
REQ-014 ACCESS with apb_ready_in=0 and counter == TIMEOUT_CYCLE-1: abort; other_done_out=1, other_error_out=1, other_rdata_out=0, psel=0, penable=0, go IDLE.
REQ-015 apb_ready_in=1 on the timeout cycle SHALL win (normal completion, REQ-012).
REQ-016 Counter width SHALL be $clog2(TIMEOUT_CYCLE+1) bits, never wraps.
REQ-017 other_done_out SHALL be high for exactly one cycle per transfer; other_rdata_out/other_error_out hold until next completion.
REQ-018 Minimum transfer: request accepted edge N, psel at N, penable at N+1, done at N+2 with zero wait states; next acceptance no earlier than N+2 (ready_out high in cycle after N+2).
REQ-019 apb_slverr_in and apb_rdata_in SHALL be ignored outside ACCESS-with-ready.

Reset
REQ-020 apb_rst_in=1 at a rising edge SHALL force IDLE and zero all registered outputs and the counter, overriding any state, including mid-SETUP/ACCESS; no done pulse for an aborted transfer.
REQ-021 During reset other_ready_out SHALL be 0.

Verification
REQ-022 Write 0x0000_0010 data 0xA5A5_5A5A strb 0xF, ready=1 in first ACCESS -> psel 2 cycles, penable 1 cycle, done=1, error=0, rdata=0.
REQ-023 Read 0x0000_0020, ready low 3 ACCESS cycles then high with rdata 0x1234_5678 -> addr stable 5 cycles, done with rdata 0x1234_5678, error=0.
REQ-024 Read with slave never ready, TIMEOUT_CYCLE=16 -> exactly 16 ACCESS cycles, done=1, error=1, rdata=0, back to IDLE.
REQ-025 Write with ready=1 and slverr=1 -> done=1, error=1; read with strb input 0xF -> apb_strb_out=0.
REQ-026 Reset asserted in second ACCESS cycle -> next edge psel=0, penable=0, all outputs 0, no done pulse, ready_out=1 after reset release.
REQ-027 other_req_in held high continuously -> back-to-back transfers, one per 3 cycles, one done pulse each, psel low in each IDLE cycle.
